// File: rtl/acquire_trig_if.sv
// Arbiter/ADC/RAM-facing signal bundle for acquire_trig.
// Optional macro ACQ_DECIM_EN adds the decim control input.
interface acquire_trig_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10
);
  logic              grant_acq;
  logic              done_acq;
  logic [DATA_W-1:0] adc_data;
  logic [DATA_W-1:0] trig_level;
  logic              trig_rise;
  logic              force_trig;
`ifdef ACQ_DECIM_EN
  logic [7:0]        decim;
`endif
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic [ADDR_W-1:0] trig_addr;
  logic              triggered;

  // Arbiter / front-end / RAM side
  modport master (
    output grant_acq, adc_data, trig_level, trig_rise, force_trig,
`ifdef ACQ_DECIM_EN
    output decim,
`endif
    input  done_acq, wr_addr, wr_data, wr_en, trig_addr, triggered
  );

  // Acquisition block side
  modport slave (
    input  grant_acq, adc_data, trig_level, trig_rise, force_trig,
`ifdef ACQ_DECIM_EN
    input  decim,
`endif
    output done_acq, wr_addr, wr_data, wr_en, trig_addr, triggered
  );
endinterface

// File: rtl/acquire_trig.sv
// Triggered ADC capture into a circular sample RAM with pre-trigger history.
// Optional macro ACQ_DECIM_EN: sample only every decim+1 cycles.
module acquire_trig #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned RAM_SIZE = 1024,
  parameter int unsigned PRE_TRIG = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  acquire_trig_if.slave bus
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned POST_N = RAM_SIZE - PRE_TRIG - 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_SIZE - 1);
  localparam logic [CNT_W-1:0]  PRE_CNT   = CNT_W'(PRE_TRIG);
  localparam logic [CNT_W-1:0]  POST_CNT  = CNT_W'(POST_N);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic              wr_en_q,     wr_en_d;
  logic [DATA_W-1:0] wr_data_q,   wr_data_d;
  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic [ADDR_W-1:0] ptr_q,       ptr_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [DATA_W-1:0] prev_q,      prev_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              triggered_q, triggered_d;
  logic              done_acq_q,  done_acq_d;
`ifdef ACQ_DECIM_EN
  logic [7:0]        div_q,       div_d;
  logic [7:0]        decim_q,     decim_d;
`endif

  logic              active_c;
  logic              tick_c;
  logic              sample_c;
  logic              rise_hit_c;
  logic              fall_hit_c;
  logic              trig_hit_c;
  logic [ADDR_W-1:0] ptr_inc_c;
  logic [CNT_W-1:0]  cnt_inc_c;

  // Sample strobe, trigger detection and address/count increments
`ifdef ACQ_DECIM_EN
  assign tick_c = (div_q == decim_q);
`else
  assign tick_c = 1'b1;
`endif
  assign active_c   = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
  assign sample_c   = active_c && bus.grant_acq && tick_c;
  assign rise_hit_c = bus.trig_rise && (prev_q < bus.trig_level) &&
                      (bus.adc_data >= bus.trig_level);
  assign fall_hit_c = !bus.trig_rise && (prev_q >= bus.trig_level) &&
                      (bus.adc_data < bus.trig_level);
  assign trig_hit_c = bus.force_trig || rise_hit_c || fall_hit_c;
  assign ptr_inc_c  = (ptr_q == LAST_ADDR) ? '0 : ptr_q + ADDR_W'(1);
  assign cnt_inc_c  = cnt_q + CNT_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; losing the grant aborts any active phase
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.grant_acq) state_d = (PRE_TRIG == 0) ? S_ARMED : S_PRE;
      end
      S_PRE: begin
        if (!bus.grant_acq)                         state_d = S_IDLE;
        else if (sample_c && (cnt_inc_c == PRE_CNT)) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!bus.grant_acq)           state_d = S_IDLE;
        else if (sample_c && trig_hit_c) state_d = (POST_N == 0) ? S_DONE : S_POST;
      end
      S_POST: begin
        if (!bus.grant_acq)                          state_d = S_IDLE;
        else if (sample_c && (cnt_inc_c == POST_CNT)) state_d = S_DONE;
      end
      S_DONE: begin
        if (!bus.grant_acq) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; every sample becomes one write a cycle later
  always_comb begin
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    wr_addr_d   = wr_addr_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    trig_addr_d = trig_addr_q;
    triggered_d = triggered_q;
    done_acq_d  = 1'b0;
`ifdef ACQ_DECIM_EN
    div_d       = div_q;
    decim_d     = decim_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        triggered_d = 1'b0;
        if (bus.grant_acq) begin
          wr_addr_d = '0;
          ptr_d     = '0;
          cnt_d     = '0;
`ifdef ACQ_DECIM_EN
          div_d     = '0;
          decim_d   = bus.decim;
`endif
        end
      end
      S_PRE, S_ARMED, S_POST: begin
        if (!bus.grant_acq) begin
          triggered_d = 1'b0;
        end else begin
`ifdef ACQ_DECIM_EN
          div_d = tick_c ? '0 : div_q + 8'd1;
`endif
          if (sample_c) begin
            wr_en_d   = 1'b1;
            wr_data_d = bus.adc_data;
            wr_addr_d = ptr_q;
            ptr_d     = ptr_inc_c;
            prev_d    = bus.adc_data;
            cnt_d     = cnt_inc_c;
            // ARMED restarts the counter so POST counts from zero
            if (state_q == S_ARMED) begin
              cnt_d = '0;
              if (trig_hit_c) begin
                trig_addr_d = ptr_q;
                triggered_d = 1'b1;
              end
            end
          end
        end
      end
      S_DONE: begin
        if (bus.grant_acq) done_acq_d  = 1'b1;
        else               triggered_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      wr_addr_q   <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      prev_q      <= '0;
      trig_addr_q <= '0;
      triggered_q <= 1'b0;
      done_acq_q  <= 1'b0;
`ifdef ACQ_DECIM_EN
      div_q       <= '0;
      decim_q     <= '0;
`endif
    end else begin
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      wr_addr_q   <= wr_addr_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      trig_addr_q <= trig_addr_d;
      triggered_q <= triggered_d;
      done_acq_q  <= done_acq_d;
`ifdef ACQ_DECIM_EN
      div_q       <= div_d;
      decim_q     <= decim_d;
`endif
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.trig_addr = trig_addr_q;
  assign bus.triggered = triggered_q;
  assign bus.done_acq  = done_acq_q;

endmodule

// File: tb/tb_acquire_trig.sv
// Self-checking bench for acquire_trig: default instance driven from a vector
// table with a write scoreboard, plus a 1536-deep PRE_TRIG=0 instance.
module tb_acquire_trig;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  acquire_trig_if #(.DATA_W(8), .ADDR_W(10)) bus ();
  acquire_trig_if #(.DATA_W(8), .ADDR_W(11)) bus_b ();

  acquire_trig #(
    .DATA_W(8), .ADDR_W(10), .RAM_SIZE(1024), .PRE_TRIG(256)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  acquire_trig #(
    .DATA_W(8), .ADDR_W(11), .RAM_SIZE(1536), .PRE_TRIG(0)
  ) u_big (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    int         mode;
    logic [7:0] lvl;
    logic       rise;
    int         f_from;
    int         f_to;
    int         abort_at;
    int         trig_k;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [17:0] sb_q[$];
  logic [7:0]  ram[1024];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int mode, input int k);
    case (mode)
      2:       return 8'((k * 7 + 3) & 127);
      3:       return 8'(200 - (k % 201));
      default: return 8'(k);
    endcase
  endfunction

  // Scoreboard: every write strobe must match the oldest expected {addr,data}
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      ram[bus.wr_addr] = bus.wr_data;
      if (sb_q.size() == 0) begin
        check("unexpected_write", 32'({bus.wr_addr, bus.wr_data}), 32'h3ffff);
      end else begin
        logic [17:0] e;
        e = sb_q.pop_front();
        check("write_addr_data", 32'({bus.wr_addr, bus.wr_data}), 32'(e));
      end
    end
  end

  // One capture on the default instance; sample k is written to k mod 1024
  task automatic run_capture(input vec_t r);
    int         n;
    logic [9:0] ta;
    logic [9:0] oldest;
    n  = (r.abort_at >= 0) ? r.abort_at : r.trig_k + 768;
    ta = 10'(r.trig_k % 1024);
    oldest = 10'((r.trig_k - 256) % 1024);
    bus.trig_level = r.lvl;
    bus.trig_rise  = r.rise;
    bus.force_trig = 1'b0;
    bus.grant_acq  = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      bus.adc_data   = pat(r.mode, k);
      bus.force_trig = (k >= r.f_from) && (k <= r.f_to);
      sb_q.push_back({10'(k % 1024), pat(r.mode, k)});
      @(posedge clk); #1;
    end
    bus.force_trig = 1'b0;
    if (r.abort_at >= 0) begin
      bus.grant_acq = 1'b0;
      @(negedge clk);
      check("triggered_before_abort", 32'(bus.triggered), 32'(r.abort_at > r.trig_k));
      @(posedge clk); @(negedge clk);
      check("abort_wr_en", 32'(bus.wr_en), 32'(0));
      check("abort_triggered", 32'(bus.triggered), 32'(0));
      repeat (4) begin
        @(negedge clk);
        check("abort_done", 32'(bus.done_acq), 32'(0));
      end
    end else begin
      @(negedge clk);
      check("done_during_last_write", 32'(bus.done_acq), 32'(0));
      @(negedge clk);
      check("done_set", 32'(bus.done_acq), 32'(1));
      check("done_wr_en", 32'(bus.wr_en), 32'(0));
      check("triggered", 32'(bus.triggered), 32'(1));
      check("trig_addr", 32'(bus.trig_addr), 32'(ta));
      check("ram_trig_sample", 32'(ram[ta]), 32'(pat(r.mode, r.trig_k)));
      check("ram_oldest_sample", 32'(ram[oldest]), 32'(pat(r.mode, r.trig_k - 256)));
      bus.grant_acq = 1'b0;
      @(negedge clk);
      check("done_cleared", 32'(bus.done_acq), 32'(0));
      check("triggered_cleared", 32'(bus.triggered), 32'(0));
    end
    check("scoreboard_empty", 32'(sb_q.size()), 32'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{mode: 1, lvl: 8'd100, rise: 1'b1, f_from: -1,   f_to: -1,   abort_at: -1,  trig_k: 356};
    tbl[1] = '{mode: 2, lvl: 8'd200, rise: 1'b1, f_from: 3500, f_to: 3500, abort_at: -1,  trig_k: 3500};
    tbl[2] = '{mode: 3, lvl: 8'd50,  rise: 1'b0, f_from: -1,   f_to: -1,   abort_at: -1,  trig_k: 352};
    tbl[3] = '{mode: 1, lvl: 8'd100, rise: 1'b1, f_from: -1,   f_to: -1,   abort_at: 456, trig_k: 356};
    tbl[4] = '{mode: 2, lvl: 8'd200, rise: 1'b1, f_from: 300,  f_to: 300,  abort_at: -1,  trig_k: 300};
    tbl[5] = '{mode: 2, lvl: 8'd200, rise: 1'b1, f_from: 250,  f_to: 256,  abort_at: -1,  trig_k: 256};
    tbl[6] = '{mode: 1, lvl: 8'd255, rise: 1'b1, f_from: -1,   f_to: -1,   abort_at: -1,  trig_k: 511};
    tbl[7] = '{mode: 1, lvl: 8'd10,  rise: 1'b0, f_from: -1,   f_to: -1,   abort_at: -1,  trig_k: 256};

    rst_n = 1'b0;
    bus.grant_acq = 1'b0;   bus.adc_data = '0;   bus.trig_level = '0;
    bus.trig_rise = 1'b1;   bus.force_trig = 1'b0;
    bus_b.grant_acq = 1'b0; bus_b.adc_data = '0; bus_b.trig_level = '0;
    bus_b.trig_rise = 1'b1; bus_b.force_trig = 1'b0;
`ifdef ACQ_DECIM_EN
    bus.decim = 8'd0;
    bus_b.decim = 8'd0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", 32'(bus.wr_en), 32'(0));
    check("rst_wr_addr", 32'(bus.wr_addr), 32'(0));
    check("rst_wr_data", 32'(bus.wr_data), 32'(0));
    check("rst_done", 32'(bus.done_acq), 32'(0));
    check("rst_trig_addr", 32'(bus.trig_addr), 32'(0));
    check("rst_triggered", 32'(bus.triggered), 32'(0));
    check("rst_big_wr_en", 32'(bus_b.wr_en), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1536-deep, PRE_TRIG=0, forced at grant: contiguous ramp at 0..1535
    bus_b.grant_acq  = 1'b1;
    bus_b.force_trig = 1'b1;
    @(posedge clk); #1;
    bus_b.adc_data = 8'd0;
    for (int k = 0; k < 1536; k++) begin
      @(posedge clk); #1;
      bus_b.adc_data   = 8'(k + 1);
      bus_b.force_trig = 1'b0;
      @(negedge clk);
      check("big_write", 32'({bus_b.wr_en, bus_b.wr_addr, bus_b.wr_data}),
            32'({1'b1, 11'(k), 8'(k)}));
      if (k == 1535) check("big_done_on_last_write", 32'(bus_b.done_acq), 32'(0));
    end
    @(negedge clk);
    check("big_done", 32'(bus_b.done_acq), 32'(1));
    check("big_wr_en_off", 32'(bus_b.wr_en), 32'(0));
    check("big_trig_addr", 32'(bus_b.trig_addr), 32'(0));
    bus_b.grant_acq = 1'b0;
    @(negedge clk);
    check("big_done_cleared", 32'(bus_b.done_acq), 32'(0));
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_capture(tbl[i]);

    // Reset while ARMED returns every output to its reset value
    bus.trig_level = 8'd200;
    bus.trig_rise  = 1'b1;
    bus.grant_acq  = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 300; k++) begin
      bus.adc_data = pat(2, k);
      sb_q.push_back({10'(k), pat(2, k)});
      @(posedge clk); #1;
    end
    check("pre_reset_triggered", 32'(bus.triggered), 32'(0));
    rst_n = 1'b0;
    bus.grant_acq = 1'b0;
    @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("midrst_wr_en", 32'(bus.wr_en), 32'(0));
    check("midrst_wr_addr", 32'(bus.wr_addr), 32'(0));
    check("midrst_wr_data", 32'(bus.wr_data), 32'(0));
    check("midrst_done", 32'(bus.done_acq), 32'(0));
    check("midrst_trig_addr", 32'(bus.trig_addr), 32'(0));
    check("midrst_triggered", 32'(bus.triggered), 32'(0));
    check("midrst_scoreboard_empty", 32'(sb_q.size()), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_capture(tbl[0]);

`ifdef ACQ_DECIM_EN
    // decim=3: one write every fourth cycle
    bus.decim      = 8'd3;
    bus.adc_data   = 8'h5a;
    bus.trig_level = 8'd200;
    bus.grant_acq  = 1'b1;
    for (int i = 0; i < 4; i++) sb_q.push_back({10'(i), 8'h5a});
    @(posedge clk); #1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      check("decim_wr_en", 32'(bus.wr_en), 32'((c > 1) && ((c - 1) % 4 == 0)));
    end
    bus.grant_acq = 1'b0;
    repeat (3) @(posedge clk);
    check("decim_scoreboard_empty", 32'(sb_q.size()), 32'(0));
    bus.decim = 8'd0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
